// File: rtl/time_setter.sv
// Key-driven editor for a BCD hh:mm:ss time: captures the live time, lets the
// user step hours/minutes/seconds, then hands the result back with a load pulse.
module time_setter #(
  parameter int BLINK_N = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_mode,
  input  logic        key_next,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load,
  output logic        editing,
  output logic [5:0]  blank
);

  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           keys;
  logic [3:0]           keys_prev_q;
  logic [3:0]           edges;
  logic [23:0]          shadow_q, shadow_d;
  logic [BLINK_N-1:0]   cnt_q, cnt_d;
  logic                 load_q, load_d;
  logic                 editing_q, editing_d;
  logic [5:0]           blank_q, blank_d;
  logic [23:0]          norm_time;
  logic [23:0]          step_up;
  logic [23:0]          step_dn;
  logic                 in_edit_d;

  // Bit order: 3 = mode, 2 = next, 1 = inc, 0 = dec.
  assign keys  = {key_mode, key_next, key_inc, key_dec};
  assign edges = keys & ~keys_prev_q;

  function automatic logic [7:0] norm_field(input logic [7:0] v, input logic [7:0] maxv);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > maxv) return 8'h00;
    return v;
  endfunction

  // With both digits <= 9, BCD bytes order the same as their numeric values.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] maxv,
                                          input logic up);
    logic [7:0] r;
    if (up) begin
      if (v == maxv)             r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)            r = maxv;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      localparam logic [7:0] MAXV = (gi == 2) ? 8'h23 : 8'h59;
      assign norm_time[gi*8 +: 8] = norm_field(cur_time[gi*8 +: 8], MAXV);
      assign step_up[gi*8 +: 8]   = bcd_step(shadow_q[gi*8 +: 8], MAXV, 1'b1);
      assign step_dn[gi*8 +: 8]   = bcd_step(shadow_q[gi*8 +: 8], MAXV, 1'b0);
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    load_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (edges[3]) begin
          state_d  = EDIT_H;
          shadow_d = norm_time;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (edges[3]) begin
          state_d = COMMIT;
          load_d  = 1'b1;
        end else if (edges[2]) begin
          state_d = (state_q == EDIT_H) ? EDIT_M :
                    (state_q == EDIT_M) ? EDIT_S : EDIT_H;
        end else if (edges[1] ^ edges[0]) begin
          case (state_q)
            EDIT_H:  shadow_d[23:16] = edges[1] ? step_up[23:16] : step_dn[23:16];
            EDIT_M:  shadow_d[15:8]  = edges[1] ? step_up[15:8]  : step_dn[15:8];
            default: shadow_d[7:0]   = edges[1] ? step_up[7:0]   : step_dn[7:0];
          endcase
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_edit_d = (state_d == EDIT_H) || (state_d == EDIT_M) || (state_d == EDIT_S);
    editing_d = in_edit_d;

    // Blink phase restarts on entering edit and on every field change.
    if (!in_edit_d)                        cnt_d = '0;
    else if (state_q == IDLE || edges[2])  cnt_d = '0;
    else                                   cnt_d = cnt_q + BLINK_N'(1);

    blank_d = 6'b000000;
    if (in_edit_d && cnt_d[BLINK_N-1]) begin
      case (state_d)
        EDIT_H:  blank_d = 6'b110000;
        EDIT_M:  blank_d = 6'b001100;
        default: blank_d = 6'b000011;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    keys_prev_q <= keys;
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      editing_q <= editing_d;
      blank_q   <= blank_d;
    end
  end

  assign set_time = shadow_q;
  assign load     = load_q;
  assign editing  = editing_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_time_setter.sv
// Directed and randomized checks of time_setter against an integer-time reference
// model (hours/minutes/seconds as numbers, blink phase as a cycle count).
module tb_time_setter;

  localparam int BN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_mode, key_next, key_inc, key_dec;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        load, editing;
  logic [5:0]  blank;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0 idle, 1 hours, 2 minutes, 3 seconds, 4 commit.
  int         m_phase = 0;
  int         m_h = 0, m_m = 0, m_s = 0;
  int         m_cnt = 0;
  bit         m_load = 0;
  logic [3:0] m_prev = 4'b0;

  time_setter #(.BLINK_N(BN)) dut (
    .clk(clk), .reset(reset),
    .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc), .key_dec(key_dec),
    .cur_time(cur_time), .set_time(set_time), .load(load),
    .editing(editing), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int capture(input logic [7:0] b, input int maxv);
    int t, o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (t > 9 || o > 9 || t * 10 + o > maxv) return 0;
    return t * 10 + o;
  endfunction

  function automatic int wrap(input int v, input int modulus);
    return (v + modulus) % modulus;
  endfunction

  task automatic model_step();
    logic [3:0] lv, e;
    int d;
    lv = {key_mode, key_next, key_inc, key_dec};
    e  = lv & ~m_prev;
    m_prev = lv;
    m_load = 0;
    if (reset) begin
      m_phase = 0; m_h = 0; m_m = 0; m_s = 0; m_cnt = 0;
      return;
    end
    if (m_phase == 0) begin
      if (e[3]) begin
        m_h = capture(cur_time[23:16], 23);
        m_m = capture(cur_time[15:8], 59);
        m_s = capture(cur_time[7:0], 59);
        m_phase = 1;
        m_cnt = 0;
      end
    end else if (m_phase == 4) begin
      m_phase = 0;
    end else begin
      if (e[3]) begin
        m_phase = 4;
        m_load = 1;
        m_cnt = 0;
      end else if (e[2]) begin
        m_phase = (m_phase % 3) + 1;
        m_cnt = 0;
      end else begin
        d = (e[1] && !e[0]) ? 1 : (e[0] && !e[1]) ? -1 : 0;
        if (m_phase == 1) m_h = wrap(m_h + d, 24);
        else if (m_phase == 2) m_m = wrap(m_m + d, 60);
        else m_s = wrap(m_s + d, 60);
        m_cnt = (m_cnt + 1) % (1 << BN);
      end
    end
  endtask

  task automatic tick();
    logic [23:0] exp_time;
    logic [5:0]  exp_blank;
    bit          in_edit;
    @(posedge clk);
    model_step();
    #1;
    in_edit  = (m_phase >= 1 && m_phase <= 3);
    exp_time = {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
    exp_blank = 6'b000000;
    if (in_edit && m_cnt >= (1 << (BN - 1)))
      exp_blank = (m_phase == 1) ? 6'b110000 : (m_phase == 2) ? 6'b001100 : 6'b000011;
    check("set_time", 32'(set_time), 32'(exp_time));
    check("load", 32'(load), 32'(m_load));
    check("editing", 32'(editing), 32'(in_edit));
    check("blank", 32'(blank), 32'(exp_blank));
    if (m_load) $display("commit set_time=%06h", set_time);
  endtask

  task automatic press(input logic [3:0] k);
    {key_mode, key_next, key_inc, key_dec} = k;
    tick();
    {key_mode, key_next, key_inc, key_dec} = 4'b0000;
    tick();
  endtask

  initial begin
    int on_cnt;
    {key_mode, key_next, key_inc, key_dec} = 4'b0000;
    reset = 1'b1;
    cur_time = 24'h0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_set_time", 32'(set_time), 32'h0);
    check("reset_editing", 32'(editing), 32'h0);

    // Enter and commit unchanged.
    cur_time = 24'h235958;
    press(4'b1000);
    check("enter_editing", 32'(editing), 32'h1);
    {key_mode, key_next, key_inc, key_dec} = 4'b1000;
    tick();
    check("commit_load", 32'(load), 32'h1);
    check("commit_value", 32'(set_time), 32'h235958);
    key_mode = 1'b0;
    tick();
    check("after_commit_editing", 32'(editing), 32'h0);
    $display("scenario enter/commit done");

    // Hours wrap both ways.
    cur_time = 24'h230000;
    press(4'b1000);
    press(4'b0010);
    check("hours_wrap_up", 32'(set_time), 32'h000000);
    press(4'b0001);
    check("hours_wrap_down", 32'(set_time), 32'h230000);
    press(4'b1000);
    $display("scenario hours wrap done");

    // BCD carry on minutes, borrow on seconds.
    cur_time = 24'h120900;
    press(4'b1000);
    press(4'b0100);
    press(4'b0010);
    check("minute_carry", 32'(set_time), 32'h121000);
    press(4'b0100);
    press(4'b0001);
    check("second_borrow", 32'(set_time), 32'h121059);
    press(4'b1000);
    $display("scenario carry/borrow done");

    // Normalisation and simultaneous-edge priority.
    cur_time = 24'h2A6130;
    press(4'b1000);
    check("normalise", 32'(set_time), 32'h000030);
    press(4'b0011);
    check("inc_dec_cancel", 32'(set_time), 32'h000030);
    {key_mode, key_next, key_inc, key_dec} = 4'b1010;
    tick();
    check("mode_beats_inc_load", 32'(load), 32'h1);
    check("mode_beats_inc_value", 32'(set_time), 32'h000030);
    {key_mode, key_next, key_inc, key_dec} = 4'b0000;
    tick();
    $display("scenario normalise/priority done");

    // Blink on minutes field, then reset with keys held.
    cur_time = 24'h101010;
    press(4'b1000);
    {key_mode, key_next, key_inc, key_dec} = 4'b0100;
    tick();
    key_next = 1'b0;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (blank == 6'b001100) on_cnt++;
    end
    check("blink_on_cycles", 32'(on_cnt), 32'd8);
    key_inc = 1'b1; key_mode = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("held_through_reset_editing", 32'(editing), 32'h0);
    check("held_through_reset_time", 32'(set_time), 32'h0);
    {key_mode, key_next, key_inc, key_dec} = 4'b0000;
    tick();
    $display("scenario blink/reset done");

    // Randomized stimulus.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      key_mode = ($urandom_range(0, 7) == 0);
      key_next = ($urandom_range(0, 3) == 0);
      key_inc  = ($urandom_range(0, 2) == 0);
      key_dec  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0)
        cur_time = {to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                    to_bcd(int'($urandom_range(0, 59)))};
      else
        cur_time = 24'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
